// File: rtl/gro_pkg.sv
// Shared types and defaults for the GRO measurement sequencer.
// Holds the FSM state enum and the GRO_TOP macro-matched widths.
package gro_pkg;

    localparam int GRO_SEL_BITS = 3;
    localparam int GRO_DL_NUM   = 8;
    localparam int GRO_RPC_BITS = 16;
    localparam int GRST_CYC     = 2;
    localparam int MAX_RETRY    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRST,
        S_ARM,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_REPORT,
        S_NEXT
    } state_e;

endpackage

// File: rtl/gro_count_sampler.sv
// Double-sample stability check of the quasi-static GRO COUNT.
// Ports: clk_i/rst_ni, start_i (arm), clr_i (cancel), count_i;
// done_o/value_o/err_o are combinational on the deciding sample.
module gro_count_sampler
    import gro_pkg::*;
#(
    parameter int RPC_BITS  = GRO_RPC_BITS,
    parameter int RETRY_MAX = MAX_RETRY
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                clr_i,
    input  logic [RPC_BITS-1:0] count_i,
    output logic                done_o,
    output logic [RPC_BITS-1:0] value_o,
    output logic                err_o
);

    logic                busy_q;
    logic                have_q;
    logic [RPC_BITS-1:0] prev_q;
    logic [2:0]          retry_q;

    // Pairs overlap: each new sample is compared against the previous one.
    always_comb begin
        done_o  = 1'b0;
        err_o   = 1'b0;
        value_o = count_i;
        if (busy_q && have_q) begin
            if (count_i == prev_q) begin
                done_o = 1'b1;
            end else if (retry_q == 3'(RETRY_MAX - 1)) begin
                done_o = 1'b1;
                err_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            have_q  <= 1'b0;
            prev_q  <= '0;
            retry_q <= '0;
        end else if (clr_i) begin
            busy_q  <= 1'b0;
            have_q  <= 1'b0;
            retry_q <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            have_q  <= 1'b0;
            retry_q <= '0;
        end else if (busy_q) begin
            if (!have_q) begin
                prev_q <= count_i;
                have_q <= 1'b1;
            end else if (done_o) begin
                busy_q <= 1'b0;
                have_q <= 1'b0;
            end else begin
                prev_q  <= count_i;
                retry_q <= retry_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/gro_meas_ctrl.sv
// Sequences GRO_TOP RSTN/EN/SEL and captures COUNT per delay line.
// In: CLK, RSTN, START, SWEEP, SEL_IN, WIN_CYC, ABORT, GRO_COUNT.
// Out: GRO_RSTN/EN/SEL, RESULT*, BUSY, DONE, CFG_ERR (all registered).
module gro_meas_ctrl
    import gro_pkg::*;
#(
    parameter int SEL_BITS   = GRO_SEL_BITS,
    parameter int DL_NUM     = GRO_DL_NUM,
    parameter int RPC_BITS   = GRO_RPC_BITS,
    parameter int WIN_BITS   = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                START,
    input  logic                SWEEP,
    input  logic [SEL_BITS-1:0] SEL_IN,
    input  logic [WIN_BITS-1:0] WIN_CYC,
    input  logic                ABORT,
    input  logic [RPC_BITS-1:0] GRO_COUNT,
    output logic                GRO_RSTN,
    output logic                GRO_EN,
    output logic [SEL_BITS-1:0] GRO_SEL,
    output logic [RPC_BITS-1:0] RESULT,
    output logic [SEL_BITS-1:0] RESULT_SEL,
    output logic                RESULT_OVF,
    output logic                RESULT_ERR,
    output logic                RESULT_VALID,
    output logic                BUSY,
    output logic                DONE,
    output logic                CFG_ERR
);

    localparam int SCNT_BITS = $clog2(SETTLE_CYC + 1);
    localparam logic [SEL_BITS:0]    DL_LIM   = (SEL_BITS + 1)'(DL_NUM);
    localparam logic [SEL_BITS-1:0]  LAST_SEL = SEL_BITS'(DL_NUM - 1);
    localparam logic [WIN_BITS-1:0]  GRST_LD  = WIN_BITS'(GRST_CYC - 1);
    localparam logic [SCNT_BITS-1:0] SETL_LD  = SCNT_BITS'(SETTLE_CYC - 1);

    state_e                state_q;
    logic                  sweep_q;
    logic [WIN_BITS-1:0]   win_q;
    logic [WIN_BITS-1:0]   wcnt_q;
    logic [SCNT_BITS-1:0]  scnt_q;
    logic                  rstn_q;
    logic                  en_q;
    logic [SEL_BITS-1:0]   sel_q;
    logic [RPC_BITS-1:0]   res_q;
    logic [SEL_BITS-1:0]   res_sel_q;
    logic                  ovf_q;
    logic                  err_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  cfg_err_q;

    logic                  last_sel;
    logic                  samp_start;
    logic                  s_done;
    logic                  s_err;
    logic [RPC_BITS-1:0]   s_value;

    assign last_sel   = !sweep_q || (sel_q == LAST_SEL);
    assign samp_start = (state_q == S_SETTLE) && (scnt_q == '0);

    gro_count_sampler #(
        .RPC_BITS  (RPC_BITS),
        .RETRY_MAX (MAX_RETRY)
    ) u_sampler (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .start_i (samp_start),
        .clr_i   (ABORT),
        .count_i (GRO_COUNT),
        .done_o  (s_done),
        .value_o (s_value),
        .err_o   (s_err)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            sweep_q   <= 1'b0;
            win_q     <= '0;
            wcnt_q    <= '0;
            scnt_q    <= '0;
            rstn_q    <= 1'b0;
            en_q      <= 1'b0;
            sel_q     <= '0;
            res_q     <= '0;
            res_sel_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (state_q != S_IDLE && ABORT) begin
                state_q <= S_IDLE;
                en_q    <= 1'b0;
                rstn_q  <= 1'b1;
                busy_q  <= 1'b0;
                // A DONE already on the wire counts as the abort's DONE.
                done_q  <= !done_q;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        rstn_q <= 1'b1;
                        if (START) begin
                            if ({1'b0, SEL_IN} >= DL_LIM) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                sweep_q <= SWEEP;
                                sel_q   <= SEL_IN;
                                win_q   <= (WIN_CYC == '0) ?
                                           WIN_BITS'(1) : WIN_CYC;
                                busy_q  <= 1'b1;
                                rstn_q  <= 1'b0;
                                wcnt_q  <= GRST_LD;
                                state_q <= S_GRST;
                            end
                        end
                    end
                    S_GRST: begin
                        if (wcnt_q == '0) begin
                            rstn_q  <= 1'b1;
                            state_q <= S_ARM;
                        end else begin
                            wcnt_q <= wcnt_q - WIN_BITS'(1);
                        end
                    end
                    S_ARM: begin
                        en_q    <= 1'b1;
                        wcnt_q  <= win_q - WIN_BITS'(1);
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (wcnt_q == '0) begin
                            en_q    <= 1'b0;
                            scnt_q  <= SETL_LD;
                            state_q <= S_SETTLE;
                        end else begin
                            wcnt_q <= wcnt_q - WIN_BITS'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (scnt_q == '0) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            scnt_q <= scnt_q - SCNT_BITS'(1);
                        end
                    end
                    S_CAPTURE: begin
                        if (s_done) begin
                            res_q     <= s_value;
                            res_sel_q <= sel_q;
                            ovf_q     <= &s_value;
                            err_q     <= s_err;
                            valid_q   <= 1'b1;
                            state_q   <= S_REPORT;
                        end
                    end
                    S_REPORT: begin
                        done_q  <= last_sel;
                        state_q <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (last_sel) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            sel_q   <= sel_q + SEL_BITS'(1);
                            rstn_q  <= 1'b0;
                            wcnt_q  <= GRST_LD;
                            state_q <= S_GRST;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign GRO_RSTN     = rstn_q;
    assign GRO_EN       = en_q;
    assign GRO_SEL      = sel_q;
    assign RESULT       = res_q;
    assign RESULT_SEL   = res_sel_q;
    assign RESULT_OVF   = ovf_q;
    assign RESULT_ERR   = err_q;
    assign RESULT_VALID = valid_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign CFG_ERR      = cfg_err_q;

endmodule

// File: tb/tb_gro_meas_ctrl.sv
// Self-checking bench for gro_meas_ctrl with a behavioural GRO model.
// Table of single measurements plus hand sequences for corner cases.
module tb_gro_meas_ctrl;

    localparam int SC = 4;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic        SWEEP = 1'b0;
    logic [2:0]  SEL_IN = '0;
    logic [15:0] WIN_CYC = '0;
    logic        ABORT = 1'b0;
    logic [15:0] GRO_COUNT;
    logic        GRO_RSTN, GRO_EN;
    logic [2:0]  GRO_SEL, RESULT_SEL;
    logic [15:0] RESULT;
    logic        RESULT_OVF, RESULT_ERR, RESULT_VALID;
    logic        BUSY, DONE, CFG_ERR;

    logic        START6 = 1'b0;
    logic [2:0]  SEL6 = '0;
    logic        GRO_RSTN6, GRO_EN6;
    logic [2:0]  GRO_SEL6, RESULT_SEL6;
    logic [15:0] RESULT6;
    logic        RESULT_OVF6, RESULT_ERR6, RESULT_VALID6;
    logic        BUSY6, DONE6, CFG_ERR6;

    gro_meas_ctrl #(.SETTLE_CYC(SC)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .SWEEP(SWEEP),
        .SEL_IN(SEL_IN), .WIN_CYC(WIN_CYC), .ABORT(ABORT),
        .GRO_COUNT(GRO_COUNT), .GRO_RSTN(GRO_RSTN), .GRO_EN(GRO_EN),
        .GRO_SEL(GRO_SEL), .RESULT(RESULT), .RESULT_SEL(RESULT_SEL),
        .RESULT_OVF(RESULT_OVF), .RESULT_ERR(RESULT_ERR),
        .RESULT_VALID(RESULT_VALID), .BUSY(BUSY), .DONE(DONE),
        .CFG_ERR(CFG_ERR)
    );

    gro_meas_ctrl #(.DL_NUM(6), .SETTLE_CYC(SC)) dut6 (
        .CLK(CLK), .RSTN(RSTN), .START(START6), .SWEEP(1'b0),
        .SEL_IN(SEL6), .WIN_CYC(16'd4), .ABORT(1'b0),
        .GRO_COUNT(16'd0), .GRO_RSTN(GRO_RSTN6), .GRO_EN(GRO_EN6),
        .GRO_SEL(GRO_SEL6), .RESULT(RESULT6), .RESULT_SEL(RESULT_SEL6),
        .RESULT_OVF(RESULT_OVF6), .RESULT_ERR(RESULT_ERR6),
        .RESULT_VALID(RESULT_VALID6), .BUSY(BUSY6), .DONE(DONE6),
        .CFG_ERR(CFG_ERR6)
    );

    always #5 CLK = ~CLK;

    // GRO model: counts while enabled, then shows a mode-defined value.
    int          mode = 0;
    logic [15:0] fix_val = '0;
    logic [15:0] mcnt = '0;
    logic        tgl = 1'b0;

    always @(negedge CLK) begin
        if (!GRO_RSTN) mcnt = '0;
        else if (GRO_EN) mcnt = mcnt + 16'd1;
        tgl = ~tgl;
        case (mode)
            1: GRO_COUNT = GRO_EN ? mcnt :
                           16'(1000 + 100 * int'(GRO_SEL));
            2: GRO_COUNT = tgl ? 16'h0055 : 16'h00AA;
            default: GRO_COUNT = GRO_EN ? mcnt : fix_val;
        endcase
    end

    int n_pass = 0;
    int n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    int          cyc, n_valid, n_done, done_cyc, en_cnt, en_first;
    int          sel_bad, rstn_low, rstn_bad, low_run, last_run, rise_cyc;
    logic        prev_en, sw_cur, inj_en, inj_busy, inj_done, pre_en;
    logic [2:0]  sel_cur;
    logic [15:0] v_res[$];
    logic [2:0]  v_sel[$];
    logic        v_ovf[$];
    logic        v_err[$];
    int          v_cyc[$];

    task automatic sample();
        if (RESULT_VALID) begin
            n_valid++;
            v_res.push_back(RESULT);
            v_sel.push_back(RESULT_SEL);
            v_ovf.push_back(RESULT_OVF);
            v_err.push_back(RESULT_ERR);
            v_cyc.push_back(cyc);
        end
        if (DONE) begin
            n_done++;
            done_cyc = cyc;
        end
        if (GRO_EN) begin
            en_cnt++;
            if (en_first < 0) en_first = cyc;
        end
        if (!GRO_RSTN) begin
            rstn_low++;
            low_run++;
        end else begin
            if (low_run > 0) begin
                last_run = low_run;
                rise_cyc = cyc;
            end
            low_run = 0;
        end
        // Every window: RSTN low 2 cycles, then one ARM cycle.
        if (GRO_EN && !prev_en)
            if (last_run != 2 || cyc - rise_cyc != 1) rstn_bad++;
        if (!sw_cur && GRO_SEL != sel_cur) sel_bad++;
        prev_en = GRO_EN;
    endtask

    // cyc N = Nth cycle after the edge that samples START.
    task automatic measure(input logic sw, input logic [2:0] sel,
                           input logic [15:0] win, input int inj_at,
                           input int inj_kind, input int bound);
        n_valid = 0; n_done = 0; done_cyc = -1; en_cnt = 0;
        en_first = -1; sel_bad = 0; rstn_low = 0; rstn_bad = 0;
        low_run = 0; last_run = 0; rise_cyc = 0; prev_en = 1'b0;
        inj_en = 1'bx; inj_busy = 1'bx; inj_done = 1'bx; pre_en = 1'bx;
        v_res.delete(); v_sel.delete(); v_ovf.delete();
        v_err.delete(); v_cyc.delete();
        sw_cur = sw; sel_cur = sel;
        @(negedge CLK);
        START = 1'b1; SWEEP = sw; SEL_IN = sel; WIN_CYC = win;
        @(posedge CLK); #1;
        START = 1'b0;
        cyc = 1;
        sample();
        while (n_done == 0 && cyc < bound) begin
            if (cyc == inj_at) begin
                if (inj_kind == 1) begin
                    pre_en = GRO_EN;
                    ABORT = 1'b1;
                end else begin
                    START = 1'b1; SWEEP = 1'b1;
                    SEL_IN = 3'd1; WIN_CYC = 16'd3;
                end
            end
            @(posedge CLK); #1;
            cyc++;
            if (cyc == inj_at + 1) begin
                inj_en = GRO_EN; inj_busy = BUSY; inj_done = DONE;
                ABORT = 1'b0; START = 1'b0;
            end
            sample();
        end
        repeat (3) begin
            @(posedge CLK); #1;
            cyc++;
            sample();
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] win;
        int          mode;
        logic [15:0] val;
        logic [15:0] exp_res;
        logic        exp_ovf;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        logic        chk_res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{3'd2, 16'd4096, 0, 16'd2048, 16'd2048,
                    1'b0, 1'b0, 4096 + SC + 6, 4096, 1'b1};
        vecs[1] = '{3'd5, 16'd10, 0, 16'd1234, 16'd1234,
                    1'b0, 1'b0, 10 + SC + 6, 10, 1'b1};
        vecs[2] = '{3'd3, 16'd0, 0, 16'hFFFF, 16'hFFFF,
                    1'b1, 1'b0, 1 + SC + 6, 1, 1'b1};
        vecs[3] = '{3'd0, 16'd1, 2, 16'd0, 16'd0,
                    1'b0, 1'b1, 0, 1, 1'b0};
        vecs[4] = '{3'd7, 16'd20, 0, 16'h7FFE, 16'h7FFE,
                    1'b0, 1'b0, 20 + SC + 6, 20, 1'b1};

        #12;
        chk("rst_gro_rstn", GRO_RSTN, 0);
        chk("rst_gro_en", GRO_EN, 0);
        chk("rst_gro_sel", GRO_SEL, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_flags", {RESULT_VALID, RESULT_OVF, RESULT_ERR,
                          BUSY, DONE, CFG_ERR}, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK); #1;
        chk("rstn_after_release", GRO_RSTN, 1);

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            fix_val = vecs[i].val;
            measure(1'b0, vecs[i].sel, vecs[i].win, -1, 0,
                    int'(vecs[i].win) + 100);
            chk($sformatf("r%0d_nvalid", i), n_valid, 1);
            chk($sformatf("r%0d_ndone", i), n_done, 1);
            chk($sformatf("r%0d_en_cyc", i), en_cnt, vecs[i].exp_en);
            chk($sformatf("r%0d_en_first", i), en_first, 4);
            chk($sformatf("r%0d_rstn_seq", i), rstn_bad, 0);
            chk($sformatf("r%0d_sel_stable", i), sel_bad, 0);
            chk($sformatf("r%0d_busy_end", i), BUSY, 0);
            if (v_res.size() > 0) begin
                if (vecs[i].chk_res)
                    chk($sformatf("r%0d_result", i), v_res[0],
                        vecs[i].exp_res);
                chk($sformatf("r%0d_rsel", i), v_sel[0], vecs[i].sel);
                chk($sformatf("r%0d_ovf", i), v_ovf[0], vecs[i].exp_ovf);
                chk($sformatf("r%0d_err", i), v_err[0], vecs[i].exp_err);
                if (vecs[i].exp_lat > 0) begin
                    chk($sformatf("r%0d_latency", i), v_cyc[0],
                        vecs[i].exp_lat);
                    chk($sformatf("r%0d_done_cyc", i), done_cyc,
                        vecs[i].exp_lat + 1);
                end
            end
        end

        mode = 1;
        measure(1'b1, 3'd0, 16'd8, -1, 0, 600);
        chk("sw_nvalid", n_valid, 8);
        chk("sw_ndone", n_done, 1);
        chk("sw_en_cyc", en_cnt, 64);
        chk("sw_rstn_low", rstn_low, 16);
        chk("sw_rstn_seq", rstn_bad, 0);
        for (int i = 0; i < v_res.size(); i++) begin
            chk($sformatf("sw%0d_rsel", i), v_sel[i], i);
            chk($sformatf("sw%0d_result", i), v_res[i], 1000 + 100 * i);
        end
        if (v_cyc.size() == 8)
            chk("sw_done_cyc", done_cyc, v_cyc[7] + 1);

        mode = 0;
        fix_val = 16'd777;
        measure(1'b0, 3'd1, 16'd500, 103, 1, 700);
        chk("ab_en_before", pre_en, 1);
        chk("ab_en_after", inj_en, 0);
        chk("ab_busy_after", inj_busy, 0);
        chk("ab_done_after", inj_done, 1);
        chk("ab_nvalid", n_valid, 0);
        chk("ab_ndone", n_done, 1);

        fix_val = 16'd321;
        measure(1'b0, 3'd6, 16'd5, -1, 0, 200);
        chk("post_ab_nvalid", n_valid, 1);
        if (v_res.size() > 0) begin
            chk("post_ab_result", v_res[0], 321);
            chk("post_ab_rsel", v_sel[0], 6);
            chk("post_ab_latency", v_cyc[0], 5 + SC + 6);
        end

        fix_val = 16'd4444;
        measure(1'b0, 3'd4, 16'd30, 10, 2, 300);
        chk("busy_start_nvalid", n_valid, 1);
        chk("busy_start_ndone", n_done, 1);
        chk("busy_start_en_cyc", en_cnt, 30);
        if (v_res.size() > 0) begin
            chk("busy_start_rsel", v_sel[0], 4);
            chk("busy_start_result", v_res[0], 4444);
            chk("busy_start_latency", v_cyc[0], 30 + SC + 6);
        end

        @(negedge CLK);
        START6 = 1'b1;
        SEL6 = 3'd7;
        @(posedge CLK); #1;
        START6 = 1'b0;
        chk("cfg_err_pulse", CFG_ERR6, 1);
        chk("cfg_err_busy", BUSY6, 0);
        @(posedge CLK); #1;
        chk("cfg_err_clear", CFG_ERR6, 0);
        chk("cfg_err_busy2", BUSY6, 0);
        chk("cfg_err_rstn", GRO_RSTN6, 1);

        fix_val = 16'd55;
        @(negedge CLK);
        START = 1'b1; SWEEP = 1'b0; SEL_IN = 3'd3; WIN_CYC = 16'd200;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("mr_en_before", GRO_EN, 1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("mr_en_async", GRO_EN, 0);
        chk("mr_rstn_async", GRO_RSTN, 0);
        chk("mr_busy_async", BUSY, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK); #1;
        chk("mr_rstn_rel", GRO_RSTN, 1);
        chk("mr_en_rel", GRO_EN, 0);
        chk("mr_sel_rel", GRO_SEL, 0);
        chk("mr_result_rel", {RESULT, RESULT_SEL}, 0);
        chk("mr_flags_rel", {RESULT_VALID, RESULT_OVF, RESULT_ERR,
                             BUSY, DONE, CFG_ERR}, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/gro_meas_ctrl.md
Name: gro_meas_ctrl

Overview:
- Sequencer that drives GRO_TOP's RSTN/EN/SEL pins and captures COUNT for one delay line or a sweep of all delay lines.
- Each measurement: reset the GRO counter, gate EN for a programmable number of CLK cycles, wait for the ring to stop, capture a stable COUNT, report it with its SEL.
- Sits between a register/test interface and GRO_TOP; replaces bench-driven sequencing in silicon.

Parameters:
- SEL_BITS, 3, width of delay-line select
- DL_NUM, 8, number of delay lines (1..2^SEL_BITS)
- RPC_BITS, 16, width of GRO COUNT
- WIN_BITS, 16, width of gate-window length
- SETTLE_CYC, 4, CLK cycles between EN fall and first COUNT sample (≥1)

Ports:
- CLK  in  1  reference clock
- RSTN  in  1  asynchronous active-low reset
- START  in  1  one-cycle request; sampled only in IDLE
- SWEEP  in  1  1 = sweep SEL_IN..DL_NUM-1; 0 = single SEL_IN
- SEL_IN  in  SEL_BITS  single-mode line, or sweep start line
- WIN_CYC  in  WIN_BITS  gate length in CLK cycles; 0 treated as 1
- ABORT  in  1  cancel current operation
- GRO_COUNT  in  RPC_BITS  COUNT from GRO_TOP (RO domain, quasi-static once EN=0)
- GRO_RSTN  out  1  to GRO_TOP.RSTN
- GRO_EN  out  1  to GRO_TOP.EN
- GRO_SEL  out  SEL_BITS  to GRO_TOP.SEL
- RESULT  out  RPC_BITS  captured count
- RESULT_SEL  out  SEL_BITS  line of RESULT
- RESULT_OVF  out  1  RESULT saturated (all ones)
- RESULT_ERR  out  1  COUNT never stabilised
- RESULT_VALID  out  1  one-cycle strobe; RESULT* held until next strobe
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse after last result, or on abort
- CFG_ERR  out  1  one-cycle pulse when START has SEL_IN ≥ DL_NUM; no measurement runs

Behaviour:
- Reset values: GRO_RSTN=0, GRO_EN=0, GRO_SEL=0, RESULT=0, RESULT_SEL=0, all flags/strobes=0, BUSY=0, state IDLE. GRO_RSTN goes to 1 on the first clock edge after reset release.
- All outputs are registered.
- States:
  - IDLE: START at edge t with a valid SEL_IN latches SWEEP, SEL_IN and WIN_CYC, loads GRO_SEL=SEL_IN, goes to GRST.
  - GRST: GRO_RSTN=0 for 2 cycles (t+1, t+2).
  - ARM: 1 cycle, GRO_RSTN=1, GRO_EN=0 (t+3).
  - RUN: GRO_EN=1 for exactly WIN cycles (t+4 .. t+3+WIN).
  - SETTLE: GRO_EN=0 for SETTLE_CYC cycles.
  - CAPTURE: sample GRO_COUNT on consecutive cycles. Two equal consecutive samples end the capture with that value. Up to 4 mismatching pairs are allowed; after the 4th, use the last sample and set ERR.
  - REPORT: RESULT_VALID=1 for 1 cycle. RESULT_OVF=1 iff RESULT is all ones.
  - NEXT: in single mode, or when GRO_SEL=DL_NUM-1, pulse DONE and go to IDLE. Otherwise GRO_SEL+1, go to GRST.
- GRO_SEL is held constant from GRST through REPORT and never changes while GRO_EN=1.
- Nominal latency (no mismatches), START to RESULT_VALID: 3 + WIN + SETTLE_CYC + 2 + 1 cycles.
- ABORT in any non-IDLE state: next edge drops GRO_EN to 0, no RESULT_VALID, DONE pulses once, state returns to IDLE. ABORT has priority over all other transitions. ABORT in IDLE is ignored.
- START while BUSY: ignored. START together with ABORT in IDLE: START wins.
- Latched config is used for the whole sweep; input changes mid-sweep have no effect.
- RSTN assertion mid-RUN: GRO_EN=0 immediately (asynchronous), all state cleared.
- Counters: window counter WIN_BITS wide, settle counter ceil(log2(SETTLE_CYC+1)) wide, retry counter 3 bits. No wrap is possible: all counters are bounded.

Decomposition:
- gro_pkg holds: state enum (IDLE, GRST, ARM, RUN, SETTLE, CAPTURE, REPORT, NEXT); SEL_BITS, RPC_BITS and DL_NUM defaults matching the GRO_TOP macros; GRST_CYC=2; MAX_RETRY=4.
- One sub-module, gro_count_sampler, performs the double-sample stability compare.
  - Inputs: start, GRO_COUNT.
  - Outputs: done, value, err.

Test Plan:
- Single, SEL_IN=2, WIN_CYC=4096, GRO model frozen at 2048 after EN falls -> RESULT=2048, RESULT_SEL=2, VALID exactly once at t+4096+10 (SETTLE_CYC=4), DONE on the next cycle; GRO_SEL=2 throughout.
- Sweep from SEL_IN=0 with a per-line count of 1000+100*sel -> 8 VALID strobes with RESULT_SEL 0..7 and values 1000..1700, GRO_RSTN low 2 cycles before each window, single DONE after SEL 7.
- Model COUNT at 16'hFFFF -> RESULT_OVF=1, RESULT=16'hFFFF. Model COUNT toggling every cycle -> RESULT_ERR=1 after 4 mismatching pairs.
- ABORT at cycle 100 of RUN -> GRO_EN=0 next edge, no VALID, DONE once, BUSY=0. A following START works normally.
- SEL_IN=7 with DL_NUM=6 -> CFG_ERR pulse, BUSY stays 0. START during BUSY is ignored. WIN_CYC=0 -> GRO_EN high exactly 1 cycle.
- RSTN low mid-RUN -> GRO_EN and GRO_RSTN low with no clock edge. After release, IDLE with all outputs at reset values.
